// File: rtl/id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl
//   Decode-side hazard controller for the 5-stage 16-bit core. Looks at the
//   instruction sitting in IF/ID and decides whether the PC and IF/ID may
//   advance, whether IF/ID is flushed, and whether ID/EX takes a bubble.
//   Handles load-use interlock, taken-branch flush, data-memory freeze and HLT.
//
// Parameters
//   REG_AW    register-address width (R0 is hardwired zero)
//   LOAD_LAT  cycles a load result is unforwardable after issue (1..3)
//   FLUSH_CYC cycles IF/ID stays flushed after a taken branch (1..3)
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   ifid_*            decoded fields of the instruction held in IF/ID
//   ex_branch_taken   branch resolved taken in EX this cycle
//   mem_stall         data memory busy, whole pipe freezes
//   pc_write_en       PC may advance
//   ifid_write_en     IF/ID may load
//   ifid_flush        IF/ID cleared to NOP this edge
//   idex_bubble       ID/EX loads a NOP
//   halted            HLT has reached ID and fetch is stopped
//   stall_cycles      (HAZ_STATS_EN only) saturating count of cycles with
//                     pc_write_en low outside HALT and reset
//
// Build option: define HAZ_STATS_EN to add the stall_cycles counter/port.
// ---------------------------------------------------------------------------

// One scoreboard entry compare: does the IF/ID instruction read this
// in-flight load destination? Entries with dest R0 never match.
module id_hazard_sb_cmp #(
  parameter int REG_AW = 4
) (
  input  logic              vld,
  input  logic [REG_AW-1:0] dest,
  input  logic [REG_AW-1:0] src1,
  input  logic              src1_used,
  input  logic [REG_AW-1:0] src2,
  input  logic              src2_used,
  output logic              hit
);
  assign hit = vld && (dest != '0) &&
               ((src1_used && (src1 == dest)) || (src2_used && (src2 == dest)));
endmodule

module id_hazard_ctrl #(
  parameter int REG_AW    = 4,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifid_valid,
  input  logic [REG_AW-1:0] ifid_src1,
  input  logic              ifid_src1_used,
  input  logic [REG_AW-1:0] ifid_src2,
  input  logic              ifid_src2_used,
  input  logic [REG_AW-1:0] ifid_dest,
  input  logic              ifid_is_load,
  input  logic              ifid_is_halt,
  input  logic              ex_branch_taken,
  input  logic              mem_stall,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              halted
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int CW = 2;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Scoreboard of loads still in their unforwardable window.
  logic [LOAD_LAT-1:0]             sb_vld;
  logic [LOAD_LAT-1:0][REG_AW-1:0] sb_dest;
  logic [LOAD_LAT-1:0]             ent_hit;
  logic                            hit;
  logic                            sb_shift;
  logic                            issue;

  for (genvar g = 0; g < LOAD_LAT; g++) begin : g_sb
    id_hazard_sb_cmp #(.REG_AW(REG_AW)) u_cmp (
      .vld       (sb_vld[g]),
      .dest      (sb_dest[g]),
      .src1      (ifid_src1),
      .src1_used (ifid_src1_used),
      .src2      (ifid_src2),
      .src2_used (ifid_src2_used),
      .hit       (ent_hit[g])
    );
  end

  assign hit = |ent_hit;

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    halted        = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    sb_shift      = 1'b1;
    issue         = 1'b0;

    if (!rst) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
    end else if (state_q == S_HALT) begin
      // Terminal until reset; branch and freeze have no effect here.
      halted        = 1'b1;
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_bubble   = 1'b1;
    end else if (mem_stall) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      sb_shift      = 1'b0;
    end else if (ex_branch_taken) begin
      // Beats HLT and load-use: the IF/ID instruction is on the wrong path.
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      ifid_write_en = 1'b0;
      if (FLUSH_CYC > 1) begin
        state_d = S_FLUSH;
        cnt_d   = CW'(FLUSH_CYC - 1);
      end else begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    end else if ((state_q == S_FLUSH) && (cnt_q != '0)) begin
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      ifid_write_en = 1'b0;
      cnt_d         = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_d = S_RUN;
    end else if ((state_q == S_RUN) && ifid_valid && ifid_is_halt) begin
      // HLT itself moves on into ID/EX; fetch stops behind it.
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      state_d       = S_HALT;
    end else if ((state_q == S_RUN) && ifid_valid && hit) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_bubble   = 1'b1;
    end else begin
      issue = ifid_valid && ifid_is_load && (ifid_dest != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      sb_vld  <= '0;
      sb_dest <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (sb_shift) begin
        for (int i = LOAD_LAT - 1; i > 0; i--) begin
          sb_vld[i]  <= sb_vld[i-1];
          sb_dest[i] <= sb_dest[i-1];
        end
        sb_vld[0]  <= issue;
        sb_dest[0] <= issue ? ifid_dest : '0;
      end
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if ((state_q != S_HALT) && !pc_write_en && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
